// File: rtl/sti_dac_gen_if.sv
// sti_dac_gen_if: frame request, serial stream and bank-write signals of the serial DAC generator
interface sti_dac_gen_if #(
    parameter int DW    = 16,
    parameter int LENW  = 2,
    parameter int NBANK = 8,
    parameter int AW    = 5
);
    logic              load;
    logic              pi_ready;
    logic [DW-1:0]     pi_data;
    logic [LENW-1:0]   pi_length;
    logic              pi_fill;
    logic              pi_msb;
    logic              pi_low;
    logic              pi_end;
    logic              so_data;
    logic              so_valid;
    logic              so_ready;
    logic [NBANK-1:0]  oem_wr;
    logic [AW-1:0]     oem_addr;
    logic [7:0]        oem_dataout;
    logic              oem_finish;
    logic              oem_overflow;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, so_ready,
        input  pi_ready, so_data, so_valid, oem_wr, oem_addr, oem_dataout, oem_finish, oem_overflow
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, so_ready,
        output pi_ready, so_data, so_valid, oem_wr, oem_addr, oem_dataout, oem_finish, oem_overflow
    );
endinterface

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serialises shaped frames and packs accepted bits into bytes written round-robin over NBANK banks
module sti_dac_gen #(
    parameter int DW    = 16,
    parameter int LENW  = 2,
    parameter int NBANK = 8,
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic         clk,
    input logic         reset,
    sti_dac_gen_if.slave bus
);
    localparam int W   = 2 * DW;
    localparam int CAP = NBANK * DEPTH;
    localparam int KW  = $clog2(CAP + 1);
    localparam int LW  = ((LENW + 4) > $clog2(W + 1)) ? (LENW + 4) : $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

    state_t           state_q;
    logic [W-1:0]     word_q, ext, shaped, aligned;
    logic [LW-1:0]    len_q, cnt_q, len_d;
    logic             msb_q, end_q, valid_q, ready_q, finish_q, ovf_q;
    logic [7:0]       asm_q, byte_d, dout_q;
    logic [2:0]       bcnt_q;
    logic [KW-1:0]    k_q, k_d;
    logic [NBANK-1:0] wr_q;
    logic [AW-1:0]    addr_q;
    logic             so_bit, acc, byte_done, room, fill_wr, wr_go, last_bit;

    // The frame word is stored pre-aligned so the outgoing bit is always at a fixed end of the register
    always_comb begin
        len_d     = (LW'(bus.pi_length) + LW'(1)) << 3;
        ext       = W'(bus.pi_data);
        shaped    = (len_d == LW'(DW)) ? ext
                  : (len_d < LW'(DW))  ? (bus.pi_low ? ext & ((W'(1) << len_d) - W'(1)) : ext >> (LW'(DW) - len_d))
                  : (bus.pi_fill ? ext << (len_d - LW'(DW)) : ext);
        aligned   = bus.pi_msb ? shaped << (LW'(W) - len_d) : shaped;
        so_bit    = msb_q ? word_q[W-1] : word_q[0];
        acc       = valid_q & bus.so_ready;
        byte_done = acc & (bcnt_q == 3'd7);
        byte_d    = {asm_q[6:0], so_bit};
        room      = k_q < KW'(CAP);
        fill_wr   = state_q == FILL;
        wr_go     = (byte_done & room) | fill_wr;
        k_d       = wr_go ? k_q + KW'(1) : k_q;
        last_bit  = acc & (cnt_q == len_q - LW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            msb_q    <= 1'b0;
            end_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
            asm_q    <= '0;
            bcnt_q   <= '0;
            dout_q   <= '0;
            k_q      <= '0;
            wr_q     <= '0;
            addr_q   <= '0;
        end else begin
            wr_q <= wr_go ? NBANK'(1) << (k_q % KW'(NBANK)) : '0;
            if (wr_go) begin
                addr_q <= AW'(k_q / KW'(NBANK));
                dout_q <= fill_wr ? 8'h00 : byte_d;
            end
            k_q <= k_d;
            if (byte_done & !room) ovf_q <= 1'b1;
            if (acc) begin
                word_q <= msb_q ? word_q << 1 : word_q >> 1;
                cnt_q  <= cnt_q + LW'(1);
                bcnt_q <= bcnt_q + 3'd1;
                asm_q  <= byte_d;
            end
            case (state_q)
                IDLE: if (bus.load) begin
                    state_q <= SHIFT;
                    word_q  <= aligned;
                    len_q   <= len_d;
                    msb_q   <= bus.pi_msb;
                    end_q   <= bus.pi_end;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    ready_q <= 1'b0;
                end
                // The final byte's write is already registered here, so FILL never collides with it
                SHIFT: if (last_bit) begin
                    valid_q <= 1'b0;
                    ready_q <= !end_q;
                    state_q <= !end_q ? IDLE : (k_d >= KW'(CAP)) ? DONE : FILL;
                end
                FILL: if (k_q == KW'(CAP - 1)) state_q <= DONE;
                DONE: finish_q <= 1'b1;
            endcase
        end
    end

    assign bus.pi_ready     = ready_q;
    assign bus.so_data      = so_bit;
    assign bus.so_valid     = valid_q;
    assign bus.oem_wr       = wr_q;
    assign bus.oem_addr     = addr_q;
    assign bus.oem_dataout  = dout_q;
    assign bus.oem_finish   = finish_q;
    assign bus.oem_overflow = ovf_q;
endmodule

// File: tb/tb_sti_dac_gen.sv
// tb_sti_dac_gen: scoreboard bench; a bit-level frame model queues expected serial bits and bank writes
module tb_sti_dac_gen;
    localparam int DW = 16, LENW = 2, NBANK = 8, DEPTH = 32, AW = 5, CAP = NBANK * DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b0;

    sti_dac_gen_if #(.DW(DW), .LENW(LENW), .NBANK(NBANK), .AW(AW)) dif ();
    sti_dac_gen #(.DW(DW), .LENW(LENW), .NBANK(NBANK), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(dif.slave)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic exp_bits[$];
    logic [31:0] exp_wr[$];
    int mk, nb, cyc, n_bits, n_wr, last_wr;
    logic [7:0] masm;
    logic exp_ovf, hold_chk, hold_bit, fin_prev;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wpack(int k, logic [7:0] v);
        logic [7:0] oh;
        oh = 8'd1 << (k % NBANK);
        return {11'b0, oh, 5'(k / NBANK), v};
    endfunction

    task automatic model_clear();
        exp_bits.delete();
        exp_wr.delete();
        mk = 0; nb = 0; masm = 0; exp_ovf = 0;
        hold_chk = 0; fin_prev = 0;
    endtask

    task automatic model_frame(logic [DW-1:0] d, int len, logic fill, logic msb, logic low, logic last);
        int L, idx;
        logic b;
        L = 8 * (len + 1);
        for (int i = 0; i < L; i++) begin
            idx = msb ? L - 1 - i : i;
            if (L == DW) b = d[idx];
            else if (L < DW) b = low ? d[idx] : d[DW - L + idx];
            else if (fill) b = (idx >= L - DW) ? d[idx - (L - DW)] : 1'b0;
            else b = (idx < DW) ? d[idx] : 1'b0;
            exp_bits.push_back(b);
            masm = {masm[6:0], b};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (mk < CAP) begin
                    exp_wr.push_back(wpack(mk, masm));
                    mk++;
                end else exp_ovf = 1;
            end
        end
        if (last) while (mk < CAP) begin
            exp_wr.push_back(wpack(mk, 8'h00));
            mk++;
        end
    endtask

    // One clock: observe outputs at the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (dif.so_valid) begin
                chk("rdy_low", dif.pi_ready, 0);
                if (hold_chk) chk("hold", dif.so_data, hold_bit);
                if (dif.so_ready) begin
                    if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
                    else chk("bit", dif.so_data, exp_bits.pop_front());
                    n_bits++;
                end
                hold_chk = !dif.so_ready;
                hold_bit = dif.so_data;
            end else hold_chk = 0;
            if (|dif.oem_wr) begin
                if (exp_wr.size() == 0) chk("extra_wr", {11'b0, dif.oem_wr, dif.oem_addr, dif.oem_dataout}, 0);
                else chk("wr", {11'b0, dif.oem_wr, dif.oem_addr, dif.oem_dataout}, exp_wr.pop_front());
                n_wr++;
                last_wr = cyc;
            end
            if (dif.oem_finish && !fin_prev && !exp_ovf) chk("fin_lat", cyc - last_wr, 1);
            fin_prev = dif.oem_finish;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ready", dif.pi_ready, 1);
        chk("rst_valid", dif.so_valid, 0);
        chk("rst_wr", dif.oem_wr, 0);
        chk("rst_fin", dif.oem_finish, 0);
        chk("rst_ovf", dif.oem_overflow, 0);
        model_clear();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send(logic [DW-1:0] d, int len, logic fill, logic msb, logic low, logic last);
        int t = 0;
        while (!dif.pi_ready && t < 100) begin
            step();
            t++;
        end
        if (!dif.pi_ready) chk("ready_to", 0, 1);
        model_frame(d, len, fill, msb, low, last);
        dif.pi_data = d;
        dif.pi_length = LENW'(len);
        dif.pi_fill = fill;
        dif.pi_msb = msb;
        dif.pi_low = low;
        dif.pi_end = last;
        dif.load = 1'b1;
        step();
        dif.load = 1'b0;
        chk("lat_valid", dif.so_valid, 1);
        chk("lat_ready", dif.pi_ready, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((dif.so_valid || !dif.pi_ready) && t < 300) begin
            step();
            t++;
        end
        chk("idle_to", t < 300, 1);
        step();
        step();
    endtask

    task automatic wait_fin();
        int t = 0;
        while (!dif.oem_finish && t < 600) begin
            step();
            t++;
        end
        chk("fin_to", dif.oem_finish, 1);
        step();
    endtask

    task automatic chk_empty(string tag);
        chk({tag, "_bits_left"}, exp_bits.size(), 0);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b0, w0, t;
        dif.load = 0; dif.pi_data = 0; dif.pi_length = 0; dif.pi_fill = 0;
        dif.pi_msb = 0; dif.pi_low = 0; dif.pi_end = 0; dif.so_ready = 1;
        cyc = 0; n_bits = 0; n_wr = 0; last_wr = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        b0 = n_bits; w0 = n_wr;
        send(16'hA5C3, 0, 0, 1, 1, 0);
        repeat (8) step();
        chk("t1_bits8", n_bits - b0, 8);
        wait_idle();
        chk("t1_wr", n_wr - w0, 1);
        chk_empty("t1");

        do_reset();
        w0 = n_wr;
        send(16'h8001, 3, 1, 0, 0, 0);
        wait_idle();
        chk("t2_wr", n_wr - w0, 4);
        chk_empty("t2");

        do_reset();
        b0 = n_bits; w0 = n_wr;
        send(16'h3C5A, 1, 0, 1, 0, 0);
        repeat (5) step();
        dif.so_ready = 0;
        repeat (3) step();
        chk("t3_stall_ready", dif.pi_ready, 0);
        dif.so_ready = 1;
        wait_idle();
        chk("t3_bits", n_bits - b0, 16);
        chk("t3_wr", n_wr - w0, 2);
        chk_empty("t3");

        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 0);
            t = 0;
            while (dif.so_valid && t < 300) begin
                dif.so_ready = $urandom_range(0, 3) != 0;
                step();
                t++;
            end
            dif.so_ready = 1;
            wait_idle();
        end
        chk_empty("rnd");

        do_reset();
        w0 = n_wr;
        send(16'h1234, 1, 0, 1, 0, 0);
        wait_idle();
        send(16'hABCD, 1, 0, 0, 0, 1);
        wait_fin();
        chk("t4_wr", n_wr - w0, 256);
        chk("t4_ovf", dif.oem_overflow, 0);
        chk_empty("t4");
        dif.load = 1;
        step();
        dif.load = 0;
        step();
        chk("t4_done_ready", dif.pi_ready, 0);
        chk("t4_done_valid", dif.so_valid, 0);
        chk("t4_done_fin", dif.oem_finish, 1);

        do_reset();
        w0 = n_wr;
        for (int i = 0; i < 130; i++) send(16'(i * 16'h0101 + 16'h5A), 1, 0, 1, 0, i == 129);
        wait_fin();
        chk("t5_wr", n_wr - w0, 256);
        chk("t5_ovf", dif.oem_overflow, 1);
        chk("t5_fin", dif.oem_finish, 1);
        chk_empty("t5");

        do_reset();
        b0 = n_bits;
        send(16'hBEEF, 3, 0, 1, 0, 0);
        t = 0;
        while (n_bits - b0 < 9 && t < 50) begin
            step();
            t++;
        end
        chk("t6_bits9", n_bits - b0, 9);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", dif.so_valid, 0);
        chk("t6_ready", dif.pi_ready, 1);
        chk("t6_wr", dif.oem_wr, 0);
        model_clear();
        step();
        reset = 1'b0;
        step();
        w0 = n_wr;
        send(16'h00F0, 0, 0, 1, 1, 0);
        wait_idle();
        chk("t6_next_wr", n_wr - w0, 1);
        chk_empty("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
